// File: rtl/band_feature_window.sv
// rtl/band_feature_window.sv - windowed energy and line-length features over a filtered sample stream
module band_feature_window #(
    parameter int WIN_LEN = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [31:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_energy,
    output logic [47:0]        out_linelen,
    output logic               out_overrun
);

    localparam int CW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [63:0]        energy_acc;
    logic [47:0]        linelen_acc;
    logic signed [31:0] prev;
    logic               prev_ok;

    logic signed [63:0] square;
    logic [64:0]        energy_sum;
    logic [63:0]        energy_next;
    logic signed [32:0] diff;
    logic [32:0]        mag;
    logic [48:0]        linelen_sum;
    logic [47:0]        linelen_next;
    logic               window_done;

    always_comb begin
        square      = in_data * in_data;
        energy_sum  = {1'b0, energy_acc} + {1'b0, $unsigned(square)};
        energy_next = energy_sum[64] ? {64{1'b1}} : energy_sum[63:0];
        diff        = {in_data[31], in_data} - {prev[31], prev};
        // The very first sample after reset has no predecessor and adds nothing.
        mag         = !prev_ok ? 33'd0 : (diff[32] ? $unsigned(-diff) : $unsigned(diff));
        linelen_sum = {1'b0, linelen_acc} + {16'd0, mag};
        linelen_next = linelen_sum[48] ? {48{1'b1}} : linelen_sum[47:0];
        window_done = in_valid && (count == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            energy_acc  <= '0;
            linelen_acc <= '0;
            prev        <= '0;
            prev_ok     <= 1'b0;
            state       <= EMPTY;
            out_valid   <= 1'b0;
            out_energy  <= '0;
            out_linelen <= '0;
            out_overrun <= 1'b0;
        end else begin
            if (in_valid) begin
                prev    <= in_data;
                prev_ok <= 1'b1;
                if (window_done) begin
                    count       <= '0;
                    energy_acc  <= '0;
                    linelen_acc <= '0;
                end else begin
                    count       <= count + CW'(1);
                    energy_acc  <= energy_next;
                    linelen_acc <= linelen_next;
                end
            end

            // A held result is never overwritten; a completion that cannot be delivered is dropped.
            case (state)
                EMPTY: begin
                    if (window_done) begin
                        state       <= FULL;
                        out_valid   <= 1'b1;
                        out_energy  <= energy_next;
                        out_linelen <= linelen_next;
                    end
                end
                FULL: begin
                    if (window_done) begin
                        if (out_ready) begin
                            out_energy  <= energy_next;
                            out_linelen <= linelen_next;
                        end else begin
                            out_overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_feature_window.sv
// tb/tb_band_feature_window.sv - self-checking bench for band_feature_window with WIN_LEN=4
module tb_band_feature_window;

    localparam int WIN = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_energy;
    logic [47:0]        out_linelen;
    logic               out_overrun;

    band_feature_window #(.WIN_LEN(WIN)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_energy  (out_energy),
        .out_linelen (out_linelen),
        .out_overrun (out_overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: raw window sums kept unbounded, clamped only when a window is reported.
    logic [127:0] sum_e, sum_l;
    int           n_in_win;
    longint       m_prev;
    bit           m_prev_ok;
    bit           m_full;
    bit           m_ovr;
    logic [63:0]  m_e;
    logic [47:0]  m_l;

    localparam logic [127:0] CAP_E = 128'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] CAP_L = 128'hFFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        sum_e = 0; sum_l = 0; n_in_win = 0;
        m_prev = 0; m_prev_ok = 0;
        m_full = 0; m_ovr = 0; m_e = 0; m_l = 0;
    endtask

    task automatic model_edge(input bit rst, input bit iv, input int d, input bit rdy);
        longint sx, df;
        bit done;
        logic [63:0] res_e;
        logic [47:0] res_l;
        done = 0; res_e = 0; res_l = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (iv) begin
            sx = longint'(d);
            sum_e += 128'(sx * sx);
            if (m_prev_ok) begin
                df = sx - m_prev;
                if (df < 0) df = -df;
                sum_l += 128'(df);
            end
            m_prev = sx;
            m_prev_ok = 1;
            n_in_win++;
            if (n_in_win == WIN) begin
                done  = 1;
                res_e = (sum_e > CAP_E) ? CAP_E[63:0] : sum_e[63:0];
                res_l = (sum_l > CAP_L) ? CAP_L[47:0] : sum_l[47:0];
                sum_e = 0; sum_l = 0; n_in_win = 0;
            end
        end
        if (done) begin
            if (!m_full || rdy) begin
                m_full = 1; m_e = res_e; m_l = res_l;
            end else begin
                m_ovr = 1;
            end
        end else if (m_full && rdy) begin
            m_full = 0;
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output after the edge.
    task automatic step(input bit rst, input bit iv, input int d, input bit rdy);
        reset = rst; in_valid = iv; in_data = d; out_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(rst, iv, d, rdy);
        check("out_valid",   64'(out_valid),   64'(m_full));
        check("out_energy",  out_energy,       m_e);
        check("out_linelen", 64'(out_linelen), 64'(m_l));
        check("out_overrun", 64'(out_overrun), 64'(m_ovr));
    endtask

    task automatic samples4(input int a, input int b, input int c, input int d, input bit rdy);
        step(0, 1, a, rdy);
        step(0, 1, b, rdy);
        step(0, 1, c, rdy);
        step(0, 1, d, rdy);
    endtask

    int neg_max;

    initial begin
        neg_max = 32'sh8000_0000;
        model_reset();
        reset = 1; in_valid = 0; in_data = 0; out_ready = 0;

        step(1, 0, 0, 0);
        step(1, 1, 123, 1);
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_energy",  out_energy, 64'd0);
        check("rst_overrun", 64'(out_overrun), 64'd0);

        // Window 1,2,3,4 with an idle gap carrying junk data inside it.
        step(0, 1, 1, 1);
        step(0, 1, 2, 1);
        check("gap_before_valid", 64'(out_valid), 64'd0);
        step(0, 0, 999, 1);
        step(0, 1, 3, 1);
        step(0, 1, 4, 1);
        check("w1_valid",   64'(out_valid), 64'd1);
        check("w1_energy",  out_energy, 64'd30);
        check("w1_linelen", 64'(out_linelen), 64'd3);
        step(0, 0, 0, 1);
        check("w1_drop", 64'(out_valid), 64'd0);
        check("w1_hold_energy", out_energy, 64'd30);

        // Line length crosses the window boundary (|-4-4| = 8).
        samples4(-4, 4, -4, 4, 1);
        check("w2_energy",  out_energy, 64'd64);
        check("w2_linelen", 64'(out_linelen), 64'd32);
        step(0, 0, 0, 1);

        // Energy saturation.
        step(1, 0, 0, 1);
        samples4(neg_max, neg_max, neg_max, neg_max, 1);
        check("sat_energy",  out_energy, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sat_linelen", 64'(out_linelen), 64'd0);
        step(0, 0, 0, 1);

        // Line-length of extreme alternation: three diffs of 2^32-1.
        samples4(neg_max, 32'sh7FFF_FFFF, neg_max, 32'sh7FFF_FFFF, 1);
        check("ext_linelen", 64'(out_linelen), 64'h0000_0002_FFFF_FFFD);
        step(0, 0, 0, 1);

        // Backpressure with overrun.
        step(1, 0, 0, 0);
        samples4(1, 1, 1, 1, 0);
        check("bp_first_overrun", 64'(out_overrun), 64'd0);
        samples4(2, 2, 2, 2, 0);
        check("bp_valid",   64'(out_valid), 64'd1);
        check("bp_energy",  out_energy, 64'd4);
        check("bp_linelen", 64'(out_linelen), 64'd0);
        check("bp_overrun", 64'(out_overrun), 64'd1);
        step(0, 0, 0, 1);
        check("bp_release_valid",   64'(out_valid), 64'd0);
        check("bp_release_overrun", 64'(out_overrun), 64'd1);
        step(0, 0, 0, 1);

        // Back-to-back results without a bubble.
        step(1, 0, 0, 1);
        samples4(1, 2, 3, 4, 1);
        step(0, 1, 1, 0);
        check("b2b_valid_a", 64'(out_valid), 64'd1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        check("b2b_valid_b", 64'(out_valid), 64'd1);
        check("b2b_energy",  out_energy, 64'd4);
        check("b2b_linelen", 64'(out_linelen), 64'd3);
        check("b2b_overrun", 64'(out_overrun), 64'd0);
        step(0, 0, 0, 1);

        // Partial window discarded by reset, with reset overriding in_valid.
        step(1, 0, 0, 1);
        step(0, 1, 7, 1);
        step(0, 1, 9, 1);
        step(1, 1, 11, 1);
        step(0, 1, 5, 1);
        step(0, 1, 5, 1);
        step(0, 1, 5, 1);
        check("part_no_result", 64'(out_valid), 64'd0);
        step(0, 1, 5, 1);
        check("part_energy",  out_energy, 64'd100);
        check("part_linelen", 64'(out_linelen), 64'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/band_feature_window.md
BAND_FEATURE_WINDOW -- requirements
Module: band_feature_window

Interface
REQ-001 SHALL have parameter WIN_LEN, default 256, samples per non-overlapping window (legal 2..65536).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge (mid-cycle relative to the negedge-updated filter stage).
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data carries a new filtered sample this edge.
REQ-005 SHALL have port in_data  input  32  signed filtered sample from the 6th-order bandpass stage.
REQ-006 SHALL have port out_valid  output  1  window result available.
REQ-007 SHALL have port out_ready  input  1  consumer accepts result when out_valid high.
REQ-008 SHALL have port out_energy  output  64  unsigned sum of squares over window, saturating.
REQ-009 SHALL have port out_linelen  output  48  unsigned sum of |x[n]-x[n-1]| over window, saturating.
REQ-010 SHALL have port out_overrun  output  1  sticky: a completed window was dropped.

Function
REQ-011 SHALL accept a sample on every rising edge with in_valid=1; in_valid=0 edges change no accumulator, counter or prev-sample state.
REQ-012 SHALL keep sample counter 0..WIN_LEN-1, incrementing per accepted sample, wrapping to 0 on the WIN_LEN-th.
REQ-013 SHALL compute square as signed 32x32 -> 64-bit unsigned (max 2^62) and add to 64-bit energy accumulator, clamping at 2^64-1.
REQ-014 SHALL compute diff as 33-bit signed in_data-prev, magnitude 33-bit unsigned, added to 48-bit accumulator, clamping at 2^48-1.
REQ-015 SHALL register every accepted sample as prev; line length SHALL span window boundaries (first diff of window k uses last sample of window k-1).
REQ-016 SHALL hold prev_ok=0 after reset; first sample after reset contributes diff 0 and sets prev_ok=1.
REQ-017 SHALL, on the edge accepting the WIN_LEN-th sample, form final sums including that sample and clear accumulators to 0 for the next window.
REQ-018 SHALL implement output FSM EMPTY/FULL; out_valid=1 exactly in FULL.
REQ-019 EMPTY + window completes -> load result, go FULL; out_valid rises one cycle after last-sample edge (latency 1).
REQ-020 FULL + out_ready=1, no completion -> go EMPTY next edge; out_energy/out_linelen retain last value.
REQ-021 FULL + out_ready=1 + completion same edge -> load new result, stay FULL (out_valid stays 1, no bubble).
REQ-022 FULL + out_ready=0 + completion -> keep old result unchanged, drop new result, set out_overrun=1; accumulators still restart.
REQ-023 out_overrun SHALL stay 1 until reset; out_energy/out_linelen SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Accumulation SHALL never stall; out_ready affects only output FSM.

Reset
REQ-025 reset=1 at an edge SHALL force: counter 0, both accumulators 0, prev 0, prev_ok 0, FSM EMPTY, out_valid 0, out_energy 0, out_linelen 0, out_overrun 0.
REQ-026 reset SHALL dominate in_valid and out_ready at the same edge; partial window at reset is discarded, no output produced.

Verification (WIN_LEN=4)
REQ-027 After reset, samples 1,2,3,4 with out_ready=1 -> out_valid high for one cycle, one cycle after 4th sample; energy 30, linelen 3.
REQ-028 Continue with -4,4,-4,4 -> energy 64, linelen 32 (first diff |-4-4|=8 crosses boundary).
REQ-029 Four samples of -2^31 -> energy 0xFFFF_FFFF_FFFF_FFFF (saturated), linelen 0 after reset.
REQ-030 out_ready=0, two windows (1,1,1,1 then 2,2,2,2) -> outputs hold energy 4, linelen 0; out_overrun=1 after second completion; ready=1 -> out_valid drops next edge, overrun stays 1.
REQ-031 FULL with out_ready=1 at the edge the next window completes -> out_valid never deasserts, new values appear next cycle.
REQ-032 reset pulsed after 2 samples of a window, then 5,5,5,5 -> single result energy 100, linelen 0; no result from the partial window.
